// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read channel (AR + R) between ICache (master 0) and DCache (master 1)
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   mst_ar_valid/ready/addr/id/len   per-master AR channels, packed [0]=ICache, [1]=DCache
//   mst_r_valid/ready                per-master R handshake
//   mst_r_data/id/last               R payload broadcast to both masters, ID MSB stripped
//   s_ar_valid/ready/addr/id/len     registered slave-side AR, id = {master_idx, arid}
//   s_r_valid/ready/data/id/last     slave-side R, routed back by the RID MSB
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mst_ar_valid,
    output logic [1:0]              mst_ar_ready,
    input  logic [2*ADDR_WIDTH-1:0] mst_ar_addr,
    input  logic [2*ID_WIDTH-1:0]   mst_ar_id,
    input  logic [15:0]             mst_ar_len,
    output logic [1:0]              mst_r_valid,
    input  logic [1:0]              mst_r_ready,
    output logic [DATA_WIDTH-1:0]   mst_r_data,
    output logic [ID_WIDTH-1:0]     mst_r_id,
    output logic                    mst_r_last,
    output logic                    s_ar_valid,
    input  logic                    s_ar_ready,
    output logic [ADDR_WIDTH-1:0]   s_ar_addr,
    output logic [ID_WIDTH:0]       s_ar_id,
    output logic [7:0]              s_ar_len,
    input  logic                    s_r_valid,
    output logic                    s_r_ready,
    input  logic [DATA_WIDTH-1:0]   s_r_data,
    input  logic [ID_WIDTH:0]       s_r_id,
    input  logic                    s_r_last
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
    logic [1:0][CW-1:0] cnt;
    logic [1:0] elig, dec;
    logic prio, load_ok, gnt_v, gnt, d;
    assign elig[0] = mst_ar_valid[0] && cnt[0] != CNT_MAX;
    assign elig[1] = mst_ar_valid[1] && cnt[1] != CNT_MAX;
    assign d = s_r_id[ID_WIDTH];
    // The prioritised master wins when eligible, otherwise the other one takes the slot.
    always_comb begin
        load_ok      = !s_ar_valid || s_ar_ready;
        gnt_v        = load_ok && |elig;
        gnt          = elig[prio] ? prio : ~prio;
        mst_ar_ready = (gnt_v && !rst) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
        mst_r_valid  = {d & s_r_valid, ~d & s_r_valid};
        s_r_ready    = mst_r_ready[d];
        mst_r_data   = s_r_data;
        mst_r_id     = s_r_id[ID_WIDTH-1:0];
        mst_r_last   = s_r_last;
        // A burst retires on its last handshaked beat; only the routed master can handshake.
        dec          = mst_r_valid & mst_r_ready & {2{s_r_last}};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ar_valid <= 1'b0;
            s_ar_addr  <= '0;
            s_ar_id    <= '0;
            s_ar_len   <= '0;
            prio       <= 1'b0;
        end else if (gnt_v) begin
            s_ar_valid <= 1'b1;
            s_ar_addr  <= gnt ? mst_ar_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : mst_ar_addr[ADDR_WIDTH-1:0];
            s_ar_id    <= {gnt, gnt ? mst_ar_id[2*ID_WIDTH-1:ID_WIDTH] : mst_ar_id[ID_WIDTH-1:0]};
            s_ar_len   <= gnt ? mst_ar_len[15:8] : mst_ar_len[7:0];
            prio       <= ~gnt;
        end else if (s_ar_ready) begin
            s_ar_valid <= 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt[0] <= cnt[0] + CW'(mst_ar_ready[0]) - CW'(dec[0]);
            cnt[1] <= cnt[1] + CW'(mst_ar_ready[1]) - CW'(dec[1]);
        end
    end
`ifndef SYNTHESIS
    a_cnt0_underflow: assert property (@(posedge clk) disable iff (rst) !(dec[0] && cnt[0] == '0))
        else $error("last beat for master 0 with no burst outstanding");
    a_cnt1_underflow: assert property (@(posedge clk) disable iff (rst) !(dec[1] && cnt[1] == '0))
        else $error("last beat for master 1 with no burst outstanding");
`endif
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed scoreboard bench for axi_rd_arbiter
module tb_axi_rd_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mst_ar_valid, mst_ar_ready, mst_r_valid, mst_r_ready;
    logic [63:0] mst_ar_addr;
    logic [7:0]  mst_ar_id;
    logic [15:0] mst_ar_len;
    logic [63:0] mst_r_data, s_r_data;
    logic [3:0]  mst_r_id;
    logic        mst_r_last, s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, s_r_last;
    logic [31:0] s_ar_addr;
    logic [4:0]  s_ar_id, s_r_id;
    logic [7:0]  s_ar_len;
    int total = 0;
    int bad = 0;
    bit tog = 1'b0;
    logic [44:0] arq[$];
    logic [69:0] rq[$];

    axi_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready), .mst_ar_addr(mst_ar_addr),
        .mst_ar_id(mst_ar_id), .mst_ar_len(mst_ar_len),
        .mst_r_valid(mst_r_valid), .mst_r_ready(mst_r_ready), .mst_r_data(mst_r_data),
        .mst_r_id(mst_r_id), .mst_r_last(mst_r_last),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
        .s_ar_id(s_ar_id), .s_ar_len(s_ar_len),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data),
        .s_r_id(s_r_id), .s_r_last(s_r_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && s_ar_valid && s_ar_ready) begin
            if (arq.size() == 0) chk("ar_unexpected", 80'd1, 80'd0);
            else chk("ar_beat", {s_ar_id, s_ar_addr, s_ar_len}, arq.pop_front());
        end
    end

    always @(negedge clk) begin
        logic [69:0] e;
        if (!rst && s_r_valid && s_r_ready) begin
            if (rq.size() == 0) chk("r_unexpected", 80'd1, 80'd0);
            else begin
                e = rq.pop_front();
                chk("r_beat", {mst_r_valid, mst_r_data, mst_r_id, mst_r_last},
                    {e[69] ? 2'b10 : 2'b01, e[68:0]});
            end
        end
    end

    task automatic set_m(input logic m, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        if (m) begin
            mst_ar_addr[63:32] = a; mst_ar_id[7:4] = id; mst_ar_len[15:8] = len;
        end else begin
            mst_ar_addr[31:0] = a; mst_ar_id[3:0] = id; mst_ar_len[7:0] = len;
        end
    endtask

    task automatic ar_cycle(input logic [1:0] v, input logic [1:0] exp_rdy);
        logic g;
        mst_ar_valid = v;
        @(negedge clk);
        chk("ar_ready", mst_ar_ready, exp_rdy);
        if (exp_rdy != 2'b00) begin
            g = exp_rdy[1];
            arq.push_back({g, g ? mst_ar_id[7:4] : mst_ar_id[3:0],
                           g ? mst_ar_addr[63:32] : mst_ar_addr[31:0],
                           g ? mst_ar_len[15:8] : mst_ar_len[7:0]});
        end
        @(posedge clk); #1;
    endtask

    task automatic set_r(input logic m, input logic [3:0] id, input logic [63:0] data, input logic last);
        s_r_valid = 1'b1; s_r_id = {m, id}; s_r_data = data; s_r_last = last;
        rq.push_back({m, data, id, last});
    endtask

    task automatic r_beat(input logic m, input logic [3:0] id, input logic [63:0] data, input logic last);
        logic rr;
        bit done = 1'b0;
        set_r(m, id, data, last);
        for (int c = 0; c < 8 && !done; c++) begin
            rr = tog;
            tog = ~tog;
            mst_r_ready = m ? {rr, ~rr} : {~rr, rr};
            @(negedge clk);
            chk("r_route", mst_r_valid, m ? 2'b10 : 2'b01);
            chk("r_ready", s_r_ready, rr);
            done = rr;
            @(posedge clk); #1;
        end
        s_r_valid = 1'b0; mst_r_ready = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        mst_ar_valid = 2'b11; mst_ar_addr = '0; mst_ar_id = '0; mst_ar_len = '0;
        mst_r_ready = 2'b00; s_ar_ready = 1'b0;
        s_r_valid = 1'b0; s_r_data = '0; s_r_id = '0; s_r_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ar_ready", mst_ar_ready, 2'b00);
        chk("rst_s_ar", {s_ar_valid, s_ar_id, s_ar_addr, s_ar_len}, 0);
        @(posedge clk); #1;
        rst = 1'b0; mst_ar_valid = 2'b00;
        // single m0 request, slave stalled for one cycle
        set_m(0, 32'h8000_0000, 4'h3, 8'd7);
        ar_cycle(2'b01, 2'b01);
        mst_ar_valid = 2'b00;
        @(negedge clk);
        chk("t1_s_ar", {s_ar_valid, s_ar_id, s_ar_addr, s_ar_len}, {1'b1, 5'h03, 32'h8000_0000, 8'd7});
        @(posedge clk); #1;
        s_ar_ready = 1'b1;
        ar_cycle(2'b00, 2'b00);
        @(negedge clk);
        chk("t1_s_ar_valid_drop", s_ar_valid, 1'b0);
        @(posedge clk); #1;
        // both masters every cycle: strict alternation starting at m1
        for (int k = 0; k < 4; k++) begin
            set_m(0, 32'h1000_0000 + 32'(k * 64), 4'(k), 8'd3);
            set_m(1, 32'h2000_0000 + 32'(k * 64), 4'hA, 8'd1);
            ar_cycle(2'b11, (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        ar_cycle(2'b00, 2'b00);
        chk("t2_drain", arq.size(), 0);
        // R routing: 8-beat m1 burst with toggling ready, then drain the counters
        for (int b = 0; b < 8; b++) r_beat(1, 4'h2, 64'hD000_0000_0000_0000 + 64'(b), b == 7);
        r_beat(0, 4'h3, 64'h0000_0000_0000_00A1, 1'b1);
        r_beat(0, 4'h0, 64'h0000_0000_0000_00A2, 1'b1);
        r_beat(0, 4'h1, 64'h0000_0000_0000_00A3, 1'b1);
        r_beat(1, 4'hA, 64'h0000_0000_0000_00B1, 1'b1);
        // slave stall: registered AR must hold, no master accepted
        s_ar_ready = 1'b0;
        set_m(0, 32'hABCD_0000, 4'h5, 8'd2);
        set_m(1, 32'h5555_0000, 4'h1, 8'd9);
        ar_cycle(2'b01, 2'b01);
        for (int k = 0; k < 5; k++) begin
            mst_ar_valid = 2'b11;
            @(negedge clk);
            chk("t3_ar_ready", mst_ar_ready, 2'b00);
            chk("t3_hold", {s_ar_valid, s_ar_id, s_ar_addr, s_ar_len}, {1'b1, 5'h05, 32'hABCD_0000, 8'd2});
            @(posedge clk); #1;
        end
        s_ar_ready = 1'b1;
        ar_cycle(2'b00, 2'b00);
        // m1 saturates at 4 outstanding; m0 still proceeds
        for (int k = 0; k < 4; k++) begin
            set_m(1, 32'h3000_0000 + 32'(k * 64), 4'(k), 8'd15);
            ar_cycle(2'b10, 2'b10);
        end
        set_m(0, 32'h4000_0000, 4'h6, 8'd0);
        set_m(1, 32'h3000_1000, 4'h7, 8'd15);
        ar_cycle(2'b11, 2'b01);
        mst_r_ready = 2'b10;
        set_r(1, 4'h1, 64'h0000_0000_0000_00C1, 1'b1);
        ar_cycle(2'b10, 2'b00);
        s_r_valid = 1'b0; mst_r_ready = 2'b00;
        ar_cycle(2'b10, 2'b10);
        ar_cycle(2'b10, 2'b00);
        // grant and last beat for m0 in the same cycle leave cnt[0] at 3
        set_m(0, 32'h6000_0000, 4'h8, 8'd4);
        ar_cycle(2'b01, 2'b01);
        mst_r_ready = 2'b01;
        set_r(0, 4'h6, 64'h0000_0000_0000_00E1, 1'b1);
        ar_cycle(2'b01, 2'b01);
        s_r_valid = 1'b0; mst_r_ready = 2'b00;
        ar_cycle(2'b01, 2'b01);
        ar_cycle(2'b01, 2'b00);
        mst_r_ready = 2'b01;
        set_r(0, 4'h8, 64'h0000_0000_0000_00E2, 1'b1);
        ar_cycle(2'b00, 2'b00);
        s_r_valid = 1'b0; mst_r_ready = 2'b00;
        s_ar_ready = 1'b0;
        ar_cycle(2'b01, 2'b01);
        // asynchronous reset in the middle of a stalled AR and an R burst
        mst_ar_valid = 2'b11;
        s_r_valid = 1'b1; s_r_id = 5'h12; s_r_data = 64'hF0; s_r_last = 1'b0;
        @(negedge clk);
        chk("t6_pre_rst", {mst_ar_ready, s_ar_valid, mst_r_valid}, {2'b00, 1'b1, 2'b10});
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_s_ar", {s_ar_valid, s_ar_id, s_ar_addr, s_ar_len}, 0);
        chk("t6_rst_ar_ready", mst_ar_ready, 2'b00);
        arq.delete();
        s_r_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        // counters and priority restart from zero
        s_ar_ready = 1'b1;
        set_m(0, 32'h7000_0000, 4'h9, 8'd1);
        set_m(1, 32'h7100_0000, 4'hB, 8'd2);
        ar_cycle(2'b11, 2'b01);
        ar_cycle(2'b10, 2'b10);
        ar_cycle(2'b00, 2'b00);
        chk("end_arq_empty", arq.size(), 0);
        chk("end_rq_empty", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
